// File: rtl/ex_mem_regs.sv
// EX/MEM pipeline register built as a 2-entry skid buffer with valid/ready handshaking.
// Also exports load-destination information for load-use hazard detection in ID.
module ex_mem_regs #(
    parameter int                   CPU_WIDTH      = 64,
    parameter int                   REG_ADDR_WIDTH = 5,
    parameter logic [CPU_WIDTH-1:0] RESET_PC       = 64'h8000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      ex_valid_i,
    output logic                      ex_ready_o,
    input  logic [CPU_WIDTH-1:0]      pc_i,
    input  logic [CPU_WIDTH-1:0]      alu_result_i,
    input  logic [CPU_WIDTH-1:0]      store_data_i,
    input  logic [7:0]                wmask_i,
    input  logic                      s_flag_i,
    input  logic [2:0]                rd_flag_i,
    input  logic [3:0]                expand_signed_i,
    input  logic                      reg_wen_i,
    input  logic [REG_ADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                      ebreak_i,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic [CPU_WIDTH-1:0]      pc_o,
    output logic [CPU_WIDTH-1:0]      alu_result_o,
    output logic [CPU_WIDTH-1:0]      store_data_o,
    output logic [7:0]                wmask_o,
    output logic                      s_flag_o,
    output logic [2:0]                rd_flag_o,
    output logic [3:0]                expand_signed_o,
    output logic                      reg_wen_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_waddr_o,
    output logic                      ebreak_o,
    output logic [1:0]                count_o,
    output logic                      load_pending_o,
    output logic [REG_ADDR_WIDTH-1:0] load_rd_o
);

    typedef struct packed {
        logic [CPU_WIDTH-1:0]      pc;
        logic [CPU_WIDTH-1:0]      alu_result;
        logic [CPU_WIDTH-1:0]      store_data;
        logic [7:0]                wmask;
        logic                      s_flag;
        logic [2:0]                rd_flag;
        logic [3:0]                expand_signed;
        logic                      reg_wen;
        logic [REG_ADDR_WIDTH-1:0] reg_waddr;
        logic                      ebreak;
    } entry_t;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_TWO   = 2'd2;

    logic [1:0] count_q, count_d;
    logic       ready_q, ready_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    entry_t     in_entry_s;
    logic       in_fire_s, out_fire_s;

    assign in_fire_s  = ex_valid_i & ready_q;
    assign out_fire_s = mem_valid_o & mem_ready_i;

    // Pack the incoming instruction; writes to x0 are suppressed at capture time.
    always_comb begin
        in_entry_s               = '0;
        in_entry_s.pc            = pc_i;
        in_entry_s.alu_result    = alu_result_i;
        in_entry_s.store_data    = store_data_i;
        in_entry_s.wmask         = wmask_i;
        in_entry_s.s_flag        = s_flag_i;
        in_entry_s.rd_flag       = rd_flag_i;
        in_entry_s.expand_signed = expand_signed_i;
        in_entry_s.reg_wen       = reg_wen_i & (reg_waddr_i != {REG_ADDR_WIDTH{1'b0}});
        in_entry_s.reg_waddr     = reg_waddr_i;
        in_entry_s.ebreak        = ebreak_i;
    end

    // Occupancy state machine: decides next occupancy and which entry loads.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            count_d = CNT_EMPTY;
        end else begin
            case (count_q)
                CNT_EMPTY: begin
                    if (in_fire_s) begin
                        head_d  = in_entry_s;
                        count_d = CNT_ONE;
                    end else begin
                        count_d = CNT_EMPTY;
                    end
                end
                CNT_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        head_d = in_entry_s;
                    end else if (in_fire_s) begin
                        skid_d  = in_entry_s;
                        count_d = CNT_TWO;
                    end else if (out_fire_s) begin
                        count_d = CNT_EMPTY;
                    end else begin
                        count_d = CNT_ONE;
                    end
                end
                CNT_TWO: begin
                    if (out_fire_s) begin
                        head_d  = skid_q;
                        count_d = CNT_ONE;
                    end else begin
                        count_d = CNT_TWO;
                    end
                end
                default: begin
                    count_d = CNT_EMPTY;
                end
            endcase
        end
        ready_d = (count_d != CNT_TWO);
    end

    // State, ready and both payload entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CNT_EMPTY;
            ready_q <= 1'b1;
            head_q  <= '{pc: RESET_PC, default: '0};
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    // Youngest valid load wins: the skid entry is younger than the head.
    always_comb begin
        load_pending_o = 1'b0;
        load_rd_o      = {REG_ADDR_WIDTH{1'b0}};
        if ((count_q == CNT_TWO) && (skid_q.rd_flag != 3'd0)) begin
            load_pending_o = 1'b1;
            load_rd_o      = skid_q.reg_waddr;
        end else if ((count_q != CNT_EMPTY) && (head_q.rd_flag != 3'd0)) begin
            load_pending_o = 1'b1;
            load_rd_o      = head_q.reg_waddr;
        end else begin
            load_pending_o = 1'b0;
            load_rd_o      = {REG_ADDR_WIDTH{1'b0}};
        end
    end

    assign ex_ready_o      = ready_q;
    assign mem_valid_o     = (count_q != CNT_EMPTY);
    assign count_o         = count_q;
    assign pc_o            = head_q.pc;
    assign alu_result_o    = head_q.alu_result;
    assign store_data_o    = head_q.store_data;
    assign wmask_o         = head_q.wmask;
    assign s_flag_o        = head_q.s_flag;
    assign rd_flag_o       = head_q.rd_flag;
    assign expand_signed_o = head_q.expand_signed;
    assign reg_wen_o       = head_q.reg_wen;
    assign reg_waddr_o     = head_q.reg_waddr;
    assign ebreak_o        = head_q.ebreak;

endmodule
